pc_seq_ctrl: RTL

- Next-PC sequencer for the fetch stage; sits in front of the program-counter register.
- Resolves redirect priority (trap > mret > branch > sequential) and buffers any redirect that arrives while fetch is frozen.
- Runs the WFI sleep/wake state machine.
- Drives the PC register's data input and a write enable, and produces flush and sleep status for the pipeline and the CSR unit.

---
 rtl/core_pkg.sv | 24 ++
 rtl/redir_buf.sv | 53 +++++
 rtl/pc_seq_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// core_pkg
// Shared types and constants for the fetch-stage next-PC sequencer.
//   pcs_state_e  : sequencer state (RUN, SLEEP, WAKE)
//   redir_kind_e : redirect source; the numeric ordering is the priority
//                  ordering, so kinds are compared with >= directly.
//   PC_STEP      : sequential fetch increment in bytes.
package core_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SLEEP = 2'd1,
    WAKE  = 2'd2
  } pcs_state_e;

  typedef enum logic [1:0] {
    R_NONE = 2'd0,
    R_BR   = 2'd1,
    R_MRET = 2'd2,
    R_TRAP = 2'd3
  } redir_kind_e;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/redir_buf.sv
// redir_buf
// Pending-redirect register. Holds the highest-priority redirect seen while
// fetch is frozen so it can be applied on the first unfrozen cycle.
// Ports:
//   clk, rst       : clock, asynchronous active-low reset
//   cap            : capture window (fetch frozen in RUN)
//   clr            : drop the held redirect (it is being applied)
//   cand_kind/tgt  : this cycle's winning redirect candidate
//   valid/kind/target : buffered redirect
module redir_buf
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cap,
  input  logic        clr,
  input  redir_kind_e cand_kind,
  input  logic [31:0] cand_tgt,
  output logic        valid,
  output redir_kind_e kind,
  output logic [31:0] target
);

  logic        valid_reg;
  redir_kind_e kind_reg;
  logic [31:0] target_reg;
  logic        take;

  // Equal priority overwrites: the newer redirect of the same kind is the
  // one the pipeline actually asked for last.
  assign take = cap && (cand_kind != R_NONE) &&
                (!valid_reg || (cand_kind >= kind_reg));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg  <= 1'b0;
      kind_reg   <= R_NONE;
      target_reg <= '0;
    end else if (clr) begin
      valid_reg  <= 1'b0;
      kind_reg   <= R_NONE;
    end else if (take) begin
      valid_reg  <= 1'b1;
      kind_reg   <= cand_kind;
      target_reg <= cand_tgt;
    end
  end

  assign valid  = valid_reg;
  assign kind   = kind_reg;
  assign target = target_reg;

endmodule

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl
// Next-PC sequencer in front of the program-counter register. Resolves
// redirect priority (trap > mret > branch > sequential), buffers redirects
// raised while fetch is frozen, and runs the WFI sleep/wake machine.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   pc_cur                   : current PC register value
//   stall, waiting           : freeze sources (hazard, imem busy)
//   br_taken/br_target       : taken branch/jump
//   trap_req/trap_vec        : trap entry
//   mret_req/mepc            : trap return
//   wfi_exec                 : WFI retiring
//   sen_pulse, irq_en        : wake event and interrupt enable
//   pc_next, pc_we           : PC register data / load enable
//   flush                    : kill IF/ID
//   sleeping, wake_trap      : sleep status, CSR interrupt-entry strobe
//   sleep_cnt                : saturating count of cycles spent asleep
module pc_seq_ctrl
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc_cur,
  input  logic             stall,
  input  logic             waiting,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  input  logic             trap_req,
  input  logic [31:0]      trap_vec,
  input  logic             mret_req,
  input  logic [31:0]      mepc,
  input  logic             wfi_exec,
  input  logic             sen_pulse,
  input  logic             irq_en,
  output logic [31:0]      pc_next,
  output logic             pc_we,
  output logic             flush,
  output logic             sleeping,
  output logic             wake_trap,
  output logic [CNT_W-1:0] sleep_cnt
);

  pcs_state_e       state_reg, state_next;
  logic [CNT_W-1:0] sleep_cnt_reg;

  logic        frz;
  redir_kind_e cand_kind;
  logic [31:0] cand_tgt;
  logic        buf_cap, buf_clr;
  logic        buf_valid;
  redir_kind_e buf_kind;
  logic [31:0] buf_target;
  logic        use_buf;

  assign frz = stall | waiting;

  // Candidate select: later assignments override earlier ones, giving
  // trap > mret > branch.
  always_comb begin
    cand_kind = R_NONE;
    cand_tgt  = br_target;
    if (br_taken) begin
      cand_kind = R_BR;
      cand_tgt  = br_target;
    end
    if (mret_req) begin
      cand_kind = R_MRET;
      cand_tgt  = mepc;
    end
    if (trap_req) begin
      cand_kind = R_TRAP;
      cand_tgt  = trap_vec;
    end
  end

  redir_buf u_redir_buf (
    .clk       (clk),
    .rst       (rst),
    .cap       (buf_cap),
    .clr       (buf_clr),
    .cand_kind (cand_kind),
    .cand_tgt  (cand_tgt),
    .valid     (buf_valid),
    .kind      (buf_kind),
    .target    (buf_target)
  );

  // Buffered redirect wins ties against a fresh one of the same kind.
  assign use_buf = buf_valid && (buf_kind >= cand_kind);

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_cur + PC_STEP;
    pc_we      = 1'b0;
    flush      = 1'b0;
    sleeping   = 1'b0;
    wake_trap  = 1'b0;
    buf_cap    = 1'b0;
    buf_clr    = 1'b0;
    unique case (state_reg)
      RUN: begin
        if (frz) begin
          // WFI under freeze is dropped; upstream presents it again.
          buf_cap = 1'b1;
        end else if (buf_valid || (cand_kind != R_NONE)) begin
          pc_we   = 1'b1;
          flush   = 1'b1;
          buf_clr = 1'b1;
          pc_next = use_buf ? buf_target : cand_tgt;
        end else begin
          pc_we = 1'b1;
          if (wfi_exec) begin
            state_next = sen_pulse ? WAKE : SLEEP;
          end
        end
      end
      SLEEP: begin
        sleeping = 1'b1;
        if (sen_pulse) begin
          state_next = WAKE;
        end
      end
      WAKE: begin
        // Instruction memory is idle after sleep, so waiting is not honoured.
        pc_we      = 1'b1;
        flush      = 1'b1;
        state_next = RUN;
        if (irq_en) begin
          pc_next   = trap_vec;
          wake_trap = 1'b1;
        end else begin
          // pc_cur already points past the WFI.
          pc_next = pc_cur;
        end
      end
      default: begin
        state_next = RUN;
      end
    endcase
    // Outputs must drop as soon as reset asserts, not at the next edge.
    if (!rst) begin
      pc_next   = RESET_PC;
      pc_we     = 1'b0;
      flush     = 1'b0;
      sleeping  = 1'b0;
      wake_trap = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sleep_cnt_reg <= '0;
    end else if ((state_reg == SLEEP) && (sleep_cnt_reg != {CNT_W{1'b1}})) begin
      sleep_cnt_reg <= sleep_cnt_reg + 1'b1;
    end
  end

  assign sleep_cnt = sleep_cnt_reg;

endmodule
